serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand/result bit width (legal range 2..64).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: start  input  1  request a new addition; sampled on rising clk.
REQ-005 SHALL provide port: a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 SHALL provide port: b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 SHALL provide port: cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 SHALL provide port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL provide port: sum  output  WIDTH  registered result of the last completed operation.
REQ-011 SHALL provide port: carry  output  1  registered carry-out of the last completed operation.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-013 In IDLE or DONE, start=1 at edge k SHALL capture a, b and cin into internal shift registers, clear the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL add one bit pair, LSB first, with the full-adder equations s=x^y^c and c'=(x&y)|(c&(x^y)); the carry flop SHALL hold c' for the next bit.
REQ-015 The WIDTH-th RUN edge (edge k+WIDTH) SHALL copy the assembled result to sum and the final carry to carry, and enter DONE.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE, i.e. a one-cycle pulse.
REQ-017 Latency SHALL be WIDTH+1 cycles from the start edge to the first cycle with done=1.
REQ-018 start while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-019 start in DONE SHALL be accepted (back-to-back operation); done SHALL fall and busy SHALL rise on that edge.
REQ-020 DONE without start SHALL return to IDLE on the next edge.
REQ-021 sum and carry SHALL change only at completion edges and SHALL hold their values through subsequent IDLE and RUN periods.
REQ-022 Operand inputs SHALL be don't-care outside the start-accept edge.
REQ-023 Result SHALL equal (a+b+cin) mod 2^WIDTH, with carry = bit WIDTH of the full sum.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force state IDLE and busy=0, done=0, sum=0, carry=0, and clear the internal shift registers, carry flop and counter.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-026 The first start SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add port sub (input, 1, captured with the operands) requesting subtraction.
REQ-028 With SERIAL_ADDER_SUB_EN defined and sub=1, the block SHALL compute a + ~b + 1 and ignore cin; carry=1 SHALL mean no borrow (a>=b, unsigned).
REQ-029 With SERIAL_ADDER_SUB_EN defined and sub=0, behaviour SHALL match REQ-023.
REQ-030 Without SERIAL_ADDER_SUB_EN, port sub SHALL be absent and behaviour SHALL be add-only per REQ-023.

Verification (WIDTH=4)
REQ-031 Bench SHALL apply a=5, b=3, cin=0, start pulse and require busy for 4 cycles, then done=1 for 1 cycle with sum=8, carry=0.
REQ-032 Bench SHALL apply a=15, b=15, cin=1 and require sum=15, carry=1; then a=15, b=1, cin=0 and require sum=0, carry=1 (wrap-around).
REQ-033 Bench SHALL pulse start with a=1, b=1 two cycles into an operation of a=2, b=2 and require the result sum=4, done exactly once, and no second operation.
REQ-034 Bench SHALL assert rst for 1 cycle during RUN and require, immediately, busy=0, sum=0, carry=0, and no done pulse afterwards.
REQ-035 Bench SHALL hold start=1 through DONE and require back-to-back results, with done pulses exactly 5 cycles apart.
REQ-036 With SERIAL_ADDER_SUB_EN defined, bench SHALL apply sub=1, a=3, b=5 and require sum=14, carry=0; then sub=1, a=5, b=3 and require sum=2, carry=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit pair per clock, WIDTH+1 cycle latency.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a + ~b + 1 subtraction).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);
    logic [1:0] state;
    logic [WIDTH-1:0] sa, sb, sr, b_in;
    logic [CW-1:0] cnt;
    logic c, c_in, s, c_next, accept, last;
`ifdef SERIAL_ADDER_SUB_EN
    // subtraction is addition of the inverted operand with a forced carry-in
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif
    assign s      = sa[0] ^ sb[0] ^ c;
    assign c_next = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    assign accept = start && state != RUN;
    assign last   = cnt == CW'(WIDTH - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            sa    <= a;
            sb    <= b_in;
            c     <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {s, sr[WIDTH-1:1]};
            c   <= c_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                sum   <= {s, sr[WIDTH-1:1]};
                carry <= c_next;
                state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH=4) against an arithmetic model.
module tb_serial_adder;
    localparam int W = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, carry;
    logic [W-1:0] sum;
    int n_vec = 0, n_err = 0, done_cnt = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic ci, s);
        return s ? (W+1)'(x) + (W+1)'((1 << W) - 1 - y) + 1 : (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
    endfunction

    // drive one operation starting at a negedge, scramble operands while running
    task automatic run_op(input logic [W-1:0] x, y, input logic ci, s);
        logic [W:0] e;
        e = model(x, y, ci, s);
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            check("run_busy", busy, 1);
            check("run_nodone", done, 0);
        end
        @(negedge clk);
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("sum", sum, e[W-1:0]);
        check("carry", carry, e[W]);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("hold_sum", sum, e[W-1:0]);
    endtask

    initial begin
        logic [W-1:0] qa[16], qb[16];
        logic qc[16];
        logic [W:0] e;
        int d0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd5, 4'd3, 1'b0, 1'b0);
        run_op(4'd15, 4'd15, 1'b1, 1'b0);
        run_op(4'd15, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        run_op(4'd3, 4'd5, 1'b0, 1'b1);
        run_op(4'd5, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`endif
        // start during RUN must be ignored
        d0 = done_cnt;
        a = 4'd2; b = 4'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        check("ign_done_cnt", done_cnt - d0, 1);
        check("ign_sum", sum, 4);
        check("ign_busy", busy, 0);
        // asynchronous reset mid-RUN
        a = 4'd7; b = 4'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sum", sum, 0);
        check("arst_carry", carry, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle", busy, 0);
        // first start right after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd9, 4'd8, 1'b1, 1'b0);
        // start held high: accepts at relative edges 0,5,10; done seen at negedges 5,10,15
        start = 1'b1; sub = 1'b0;
        for (int j = 0; j <= 15; j++) begin
            if (j > 0) begin
                check("b2b_done", done, j % 5 == 0);
                check("b2b_busy", busy, j % 5 != 0);
                if (j % 5 == 0) begin
                    e = model(qa[j-5], qb[j-5], qc[j-5], 1'b0);
                    check("b2b_sum", sum, e[W-1:0]);
                    check("b2b_carry", carry, e[W]);
                end
            end
            qa[j] = W'($urandom); qb[j] = W'($urandom); qc[j] = 1'($urandom);
            a = qa[j]; b = qb[j]; cin = qc[j];
            if (j == 15) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_end_done", done, 0);
        check("b2b_end_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
